// File: rtl/dmem_byte_sram.sv
// dmem_byte_sram: byte-enabled data memory with latency pipeline, range check and post-reset clear
module dmem_byte_sram #(
   parameter int unsigned DEPTH_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned READ_LATENCY   = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wen,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        err_sticky,
   output logic [31:0] wr_count
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [31:0]       mem [DEPTH_WORDS];
   logic [0:0]        state;
   logic [AW-1:0]     clr_idx;
   logic [31:0]       off;
   logic [AW-1:0]     idx;
   logic              in_range, acc, wr, clr_done;
   logic [31:0]       rd_data;
   logic [READ_LATENCY-1:0] pv, pe;
   logic [31:0]       pd [READ_LATENCY];

   assign off      = req_addr - BASE_ADDR;
   assign in_range = off < 32'(4 * DEPTH_WORDS);
   assign idx      = off[AW+1:2];
   assign acc      = req_valid && req_ready && rst_n;
   assign wr       = acc && in_range && |req_wen;
   assign clr_done = state == ST_CLEAR && clr_idx == AW'(DEPTH_WORDS - 1);
   assign rd_data  = (acc && in_range && req_wen == 4'b0000) ? mem[idx] : 32'h0;

   assign rsp_valid = pv[READ_LATENCY-1];
   assign rsp_rdata = pd[READ_LATENCY-1];
   assign rsp_err   = pe[READ_LATENCY-1];

   // memory array: clear sweep has priority, otherwise byte-lane writes; never reset so contents survive
   always_ff @(posedge clk) begin
      if (rst_n && state == ST_CLEAR)
         mem[clr_idx] <= 32'h0;
      else if (wr)
         for (int k = 0; k < 4; k++)
            if (req_wen[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
   end

   // clear/run sequencing; ready is registered as "next state is RUN"
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clr_idx   <= '0;
         req_ready <= 1'b0;
      end else begin
         if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
         if (clr_done) state <= ST_RUN;
         req_ready <= state == ST_RUN || clr_done;
      end
   end

   // response pipeline; idle stages carry zeros so outputs drop to 0 between responses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pv <= '0;
         pe <= '0;
         for (int i = 0; i < int'(READ_LATENCY); i++) pd[i] <= 32'h0;
      end else begin
         pv[0] <= acc;
         pe[0] <= acc && !in_range;
         pd[0] <= rd_data;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end

   // error flag and committed-write counter, both updated at the accept edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
         wr_count   <= 32'h0;
      end else begin
         if (acc && !in_range) err_sticky <= 1'b1;
         if (wr) wr_count <= wr_count + 32'h1;
      end
   end
endmodule

// File: tb/tb_dmem_byte_sram.sv
// tb_dmem_byte_sram: scoreboard bench over two configurations of the data memory
module tb_dmem_byte_sram;
   typedef struct {
      int          due;
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n0 = 1'b0, rst_n1 = 1'b0;
   logic        valid0 = 1'b0, valid1 = 1'b0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic [3:0]  req_wen = 4'h0;
   logic        ready0, ready1, rv0, rv1, re0, re1, st0, st1;
   logic [31:0] rd0, rd1, wc0, wc1;
   int          cyc = 0;
   int          vecs = 0, errs = 0;
   exp_t        q0[$], q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_byte_sram #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n0), .req_valid(valid0), .req_ready(ready0), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wen(req_wen), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0),
      .err_sticky(st0), .wr_count(wc0));

   dmem_byte_sram #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .READ_LATENCY(4), .CLEAR_ON_RESET(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n1), .req_valid(valid1), .req_ready(ready1), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wen(req_wen), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1),
      .err_sticky(st1), .wr_count(wc1));

   task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string n, input logic act, input logic exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b, want %b (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic mon(input int i, input logic v, input logic [31:0] d, input logic e);
      exp_t x;
      logic have;
      have = 1'b0;
      if (i == 0) begin
         if (q0.size() > 0 && (v || q0[0].due <= cyc)) begin have = 1'b1; x = q0.pop_front(); end
      end else begin
         if (q1.size() > 0 && (v || q1[0].due <= cyc)) begin have = 1'b1; x = q1.pop_front(); end
      end
      if (have) begin
         vecs++;
         if (!v || x.due != cyc || d !== x.d || e !== x.e) begin
            errs++;
            $display("FAIL rsp%0d: got valid=%b cycle=%0d data=%h err=%b, want cycle=%0d data=%h err=%b",
                     i, v, cyc, d, e, x.due, x.d, x.e);
         end
      end else if (v) begin
         vecs++;
         errs++;
         $display("FAIL rsp%0d: unexpected response at cycle %0d data=%h err=%b, want none", i, cyc, d, e);
      end
   endtask

   always @(negedge clk) begin
      mon(0, rv0, rd0, re0);
      mon(1, rv1, rd1, re1);
   end

   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                        input logic [31:0] ed, input logic ee, input bit push);
      exp_t x;
      req_addr = a; req_wdata = d; req_wen = w;
      if (i == 0) valid0 = 1'b1; else valid1 = 1'b1;
      chk1("ready", i == 0 ? ready0 : ready1, 1'b1);
      @(posedge clk); #1;
      valid0 = 1'b0; valid1 = 1'b0;
      x.due = (i == 0) ? cyc + 2 : cyc + 3;
      x.d = ed;
      x.e = ee;
      if (push) begin
         if (i == 0) q0.push_back(x); else q1.push_back(x);
      end
   endtask

   task automatic drain(input int i);
      int n = 0;
      while ((i == 0 ? q0.size() : q1.size()) != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk32("drain", 32'(i == 0 ? q0.size() : q1.size()), 32'h0);
   endtask

   task automatic clear_wait();
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         chk1("clear_ready", ready0, k == 16);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_ready0", ready0, 1'b0);
      chk1("rst_valid0", rv0, 1'b0);
      chk32("rst_rdata0", rd0, 32'h0);
      chk1("rst_sticky0", st0, 1'b0);
      chk32("rst_wcount0", wc0, 32'h0);
      chk1("rst_ready1", ready1, 1'b0);
      rst_n0 = 1'b1;
      rst_n1 = 1'b1;
      @(posedge clk); #1;
      chk1("noclear_ready1", ready1, 1'b1);
      chk1("clear_ready", ready0, 1'b0);
      for (int k = 2; k <= 16; k++) begin
         @(posedge clk); #1;
         chk1("clear_ready", ready0, k == 16);
      end
      issue(0, 32'h1010, 32'h11223344, 4'b1111, 32'h0, 1'b0, 1);
      chk32("wcount_first", wc0, 32'h1);
      chk1("sticky_clean", st0, 1'b0);
      issue(0, 32'h1010, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1);
      issue(0, 32'h1010, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0, 1);
      drain(0);
      chk32("wcount_lanes", wc0, 32'h2);
      issue(0, 32'h1000, 32'h1, 4'b1111, 32'h0, 1'b0, 1);
      issue(0, 32'h1004, 32'h2, 4'b1111, 32'h0, 1'b0, 1);
      issue(0, 32'h1008, 32'h3, 4'b1111, 32'h0, 1'b0, 1);
      issue(0, 32'h1000, 32'h0, 4'b0000, 32'h1, 1'b0, 1);
      issue(0, 32'h1004, 32'h0, 4'b0000, 32'h2, 1'b0, 1);
      issue(0, 32'h1008, 32'h0, 4'b0000, 32'h3, 1'b0, 1);
      issue(0, 32'h1020, 32'hCAFE0001, 4'b1111, 32'h0, 1'b0, 1);
      issue(0, 32'h1020, 32'h0, 4'b0000, 32'hCAFE0001, 1'b0, 1);
      drain(0);
      chk32("wcount_stream", wc0, 32'h6);
      issue(0, 32'h1040, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 1);
      chk1("sticky_set", st0, 1'b1);
      chk32("wcount_oor", wc0, 32'h6);
      issue(0, 32'h0FFC, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
      issue(0, 32'h103C, 32'h0, 4'b0000, 32'h0, 1'b0, 1);
      issue(0, 32'h1014, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1);
      issue(0, 32'h1014, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1);
      drain(0);
      rst_n0 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk1("rerst_ready0", ready0, 1'b0);
      chk1("rerst_sticky0", st0, 1'b0);
      chk32("rerst_wcount0", wc0, 32'h0);
      rst_n0 = 1'b1;
      clear_wait();
      issue(0, 32'h1014, 32'h0, 4'b0000, 32'h0, 1'b0, 1);
      issue(0, 32'h1010, 32'h0, 4'b0000, 32'h0, 1'b0, 1);
      drain(0);
      issue(1, 32'h0, 32'h12345678, 4'b1111, 32'h0, 1'b0, 1);
      chk32("wcount1", wc1, 32'h1);
      issue(1, 32'h0, 32'h0, 4'b0000, 32'h12345678, 1'b0, 1);
      issue(1, 32'h40, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
      drain(1);
      chk1("sticky1", st1, 1'b1);
      issue(1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 0);
      rst_n1 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n1 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk1("flushed_valid1", rv1, 1'b0);
      end
      @(posedge clk); #1;
      chk1("flush_sticky1", st1, 1'b0);
      chk32("flush_wcount1", wc1, 32'h0);
      issue(1, 32'h0, 32'h0, 4'b0000, 32'h12345678, 1'b0, 1);
      drain(1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/dmem_byte_sram.md
# dmem_byte_sram

Parametrised, synthesizable data memory for the RV32I core's data port. It adds four things the flat word-only memory model lacked:
- per-byte write enables;
- configurable read latency behind a valid handshake;
- out-of-range error reporting;
- an optional post-reset clear sequence that zeroes every word.

It sits between the CPU's `d_mem_*` port and the top-level testbench/SoC wrapper.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, minimum 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `READ_LATENCY`, 1: accept-to-response delay in clock edges; legal range 1..4.
- `CLEAR_ON_RESET`, 1: 1 = zero all words after reset before accepting requests; 0 = skip the clear.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_addr` in 32: byte address; bits [1:0] are ignored for indexing.
- `req_wdata` in 32: write data, lane-aligned (byte k in bits [8k+7:8k]).
- `req_wen` in 4: byte-lane write enables; 4'b0000 means read.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out 32: read data; 0 for write responses and errors.
- `rsp_err` out 1: the response's request was out of range.
- `err_sticky` out 1: set by any out-of-range accepted request; cleared only by reset.
- `wr_count` out 32: count of committed in-range writes; wraps modulo 2^32.

## Operation
- **Accept.** A request is accepted on an edge where `req_valid && req_ready`. At most one request per cycle. No response backpressure.
- **Range check.** `off = req_addr - BASE_ADDR` (32-bit unsigned wrap). In range iff `off < 4*DEPTH_WORDS`. Word index is `off[log2(DEPTH_WORDS)+1:2]`.
- **In-range write** (`req_wen != 0`):
  - Only enabled lanes are updated at the accept edge; other lanes keep their value.
  - `wr_count` increments by 1.
  - Generates a response with `rsp_rdata` = 0 and `rsp_err` = 0.
- **In-range read** (`req_wen == 0`):
  - The word is sampled at the accept edge (write-first: a write accepted on the previous edge is visible).
  - The sampled value is delayed through the latency pipeline.
  - Response has `rsp_err` = 0.
- **Out-of-range request**, read or write:
  - No memory change; `wr_count` unchanged.
  - Response has `rsp_rdata` = 0 and `rsp_err` = 1.
  - `err_sticky` is set at the accept edge.
- **Response order.** Every accepted request produces exactly one response, in acceptance order.
- **FSM states.**
  - CLEAR: `clr_idx` counts from 0 to DEPTH_WORDS-1 and writes 0 to `mem[clr_idx]` on each edge. `req_ready` = 0 throughout.
  - RUN: `req_ready` = 1.
- **FSM transitions.**
  - Reset enters CLEAR with `clr_idx` = 0 if `CLEAR_ON_RESET`=1, otherwise enters RUN.
  - CLEAR moves to RUN on the edge that clears word DEPTH_WORDS-1.
  - RUN has no exit other than reset.
- **Reset mid-operation.**
  - In-flight responses are discarded; the pipeline is flushed.
  - The clear restarts at index 0.
  - With `CLEAR_ON_RESET`=0, memory contents are preserved.

## Timing
- **Reset values** (on any edge with `rst_n`=0):
  - `req_ready` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `err_sticky` 0, `wr_count` 0.
  - Pipeline valid bits 0.
- **Clear duration.** With `CLEAR_ON_RESET`=1, `req_ready` rises after exactly DEPTH_WORDS rising edges with `rst_n`=1 (1024 cycles by default). With `CLEAR_ON_RESET`=0, it rises after the first edge with `rst_n`=1.
- **Response latency.** Counting the accept edge as edge 1, `rsp_valid`, `rsp_rdata` and `rsp_err` become valid after edge READ_LATENCY. They are held for exactly one cycle, then return to 0 unless another response follows.
  - READ_LATENCY=1: registered output, valid the cycle immediately after accept.
- **Throughput.** Back-to-back requests yield back-to-back responses at 1 per cycle.
- **Write visibility.** Memory write, `wr_count` update and `err_sticky` update all take effect at the accept edge.
- **Outputs.** All outputs are registered; there is no combinational path from the `req_*` inputs to any output.

## Test plan
- **Reset clear.** Preload `mem[5]`=32'hDEADBEEF, `CLEAR_ON_RESET`=1, DEPTH_WORDS=16, rst_n pulse → `req_ready` 0 for 16 edges then 1; read 0x14 returns 32'h0.
- **Byte lanes.** Write 0x10 with 32'h11223344 / wen 4'b1111, then 32'hAABBCCDD / wen 4'b0101 → read 0x10 returns 32'h11BB33DD; `wr_count`=2.
- **Latency and streaming.** READ_LATENCY=3; reads of 0x0, 0x4, 0x8 accepted on consecutive edges (words 1, 2, 3) → `rsp_valid` high 3 consecutive cycles starting after the 3rd edge, data 1, 2, 3 in order.
- **Read-after-write.** Write 32'hCAFE0001 to 0x20 on edge N, read 0x20 on edge N+1 → response 32'hCAFE0001, `rsp_err`=0.
- **Out of range.** BASE_ADDR=32'h1000, DEPTH_WORDS=16:
  - Write to 0x1040 → response `rsp_err`=1, `rsp_rdata`=0; `err_sticky`=1; `wr_count` unchanged.
  - Read 0x0FFC (wraps below base) → `rsp_err`=1.
  - Read 0x103C → `rsp_err`=0.
- **Reset mid-flight.** READ_LATENCY=4, read accepted, `rst_n` low on the next edge → no `rsp_valid` ever appears; `err_sticky`=0 and `wr_count`=0 after reset.
